// File: rtl/work_dispatcher.sv
// work_dispatcher: buffers one 24-word work unit, shifts it into the mining core and collects the golden nonce.
// Optional WAIT_SOL watchdog: define DISPATCH_TIMEOUT_EN (adds the TIMEOUT_CYCLES parameter).
module work_dispatcher #(
  parameter int unsigned SHIFT_GAP = 32'd0
`ifdef DISPATCH_TIMEOUT_EN
  , parameter logic [31:0] TIMEOUT_CYCLES = 32'd16777216
`endif
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        host_wr_en,
  input  logic [4:0]  host_wr_addr,
  input  logic [31:0] host_wr_data,
  input  logic        host_go,
  input  logic        abort,
  input  logic        result_ack,
  output logic        busy,
  output logic        result_valid,
  output logic [31:0] result_nonce,
  output logic        timed_out,
  output logic        start_found,
  output logic        shift_in_enable,
  output logic [31:0] shift_data,
  input  logic        sol_claim,
  input  logic [31:0] sol_nonce,
  output logic        sol_response
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    START    = 3'd1,
    SEND     = 3'd2,
    WAIT_SOL = 3'd3,
    ACK      = 3'd4,
    RELEASE  = 3'd5
  } state_t;

  localparam logic [4:0]  LAST_IDX = 5'd23;
  localparam logic [4:0]  NUM_WORDS = 5'd24;
  localparam logic [15:0] GAP_LAST = SHIFT_GAP[15:0];

  state_t      state_r, state_s;
  logic [4:0]  idx_r, idx_s;
  logic [15:0] gap_r, gap_s;
  logic [31:0] buf_r [24];

  logic        busy_r;
  logic        result_valid_r;
  logic [31:0] result_nonce_r;
  logic        start_found_r;
  logic        shift_in_enable_r;
  logic [31:0] shift_data_r;
  logic        sol_response_r;

  logic        capture_s;
  logic        expire_s;
  logic        clear_pulse_s;
  logic        pulse_s;
  logic [31:0] word_s;

`ifdef DISPATCH_TIMEOUT_EN
  logic [31:0] wd_r;
  logic        timed_out_r;
`endif

  // Next-state, word index and gap counter; abort overrides everything outside IDLE.
  always_comb begin
    state_s       = state_r;
    idx_s         = idx_r;
    gap_s         = gap_r;
    capture_s     = 1'b0;
    expire_s      = 1'b0;
    clear_pulse_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (host_go && !result_valid_r) begin
          state_s = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        state_s = SEND;
        idx_s   = 5'd0;
        gap_s   = 16'd0;
      end
      SEND: begin
        if (gap_r == GAP_LAST) begin
          gap_s = 16'd0;
          if (idx_r == LAST_IDX) begin
            state_s = WAIT_SOL;
          end else begin
            idx_s = idx_r + 5'd1;
          end
        end else begin
          gap_s = gap_r + 16'd1;
        end
      end
      WAIT_SOL: begin
        if (sol_claim) begin
          capture_s = 1'b1;
          state_s   = ACK;
`ifdef DISPATCH_TIMEOUT_EN
        end else if (wd_r == (TIMEOUT_CYCLES - 32'd1)) begin
          expire_s = 1'b1;
          state_s  = IDLE;
`endif
        end else begin
          state_s = WAIT_SOL;
        end
      end
      ACK: begin
        state_s = RELEASE;
      end
      RELEASE: begin
        // a level-held claim must drop before another job can capture again
        if (!sol_claim) begin
          state_s = IDLE;
        end else begin
          state_s = RELEASE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (abort && (state_r != IDLE)) begin
      state_s       = IDLE;
      capture_s     = 1'b0;
      expire_s      = 1'b0;
      clear_pulse_s = 1'b1;
    end else begin
      clear_pulse_s = expire_s;
    end
  end

  // Word to present on the next pulse cycle.
  always_comb begin
    pulse_s = (state_s == SEND) && (gap_s == 16'd0);
    if (pulse_s && (idx_s < NUM_WORDS)) begin
      word_s = buf_r[idx_s];
    end else begin
      word_s = 32'd0;
    end
  end

  // State, buffer and registered outputs (outputs track the state being entered).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r           <= IDLE;
      idx_r             <= 5'd0;
      gap_r             <= 16'd0;
      busy_r            <= 1'b0;
      result_valid_r    <= 1'b0;
      result_nonce_r    <= 32'd0;
      start_found_r     <= 1'b0;
      shift_in_enable_r <= 1'b0;
      shift_data_r      <= 32'd0;
      sol_response_r    <= 1'b0;
      for (int i = 0; i < 24; i++) begin
        buf_r[i] <= 32'd0;
      end
    end else begin
      state_r <= state_s;
      idx_r   <= idx_s;
      gap_r   <= gap_s;
      if (host_wr_en && (state_r == IDLE) && (host_wr_addr < NUM_WORDS)) begin
        buf_r[host_wr_addr] <= host_wr_data;
      end
      busy_r            <= (state_s != IDLE);
      start_found_r     <= (state_s == START) || clear_pulse_s;
      shift_in_enable_r <= pulse_s;
      shift_data_r      <= word_s;
      sol_response_r    <= (state_s == ACK);
      if (capture_s) begin
        result_nonce_r <= sol_nonce;
      end
      if (capture_s) begin
        result_valid_r <= 1'b1;
      end else if (result_ack) begin
        result_valid_r <= 1'b0;
      end
    end
  end

`ifdef DISPATCH_TIMEOUT_EN
  // Watchdog counts cycles in WAIT_SOL; timed_out stays set until the next accepted job.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_r        <= 32'd0;
      timed_out_r <= 1'b0;
    end else begin
      if (state_r == WAIT_SOL) begin
        wd_r <= wd_r + 32'd1;
      end else begin
        wd_r <= 32'd0;
      end
      if (expire_s) begin
        timed_out_r <= 1'b1;
      end else if ((state_r == IDLE) && (state_s == START)) begin
        timed_out_r <= 1'b0;
      end
    end
  end

  assign timed_out = timed_out_r;
`else
  assign timed_out = 1'b0;
`endif

  assign busy            = busy_r;
  assign result_valid    = result_valid_r;
  assign result_nonce    = result_nonce_r;
  assign start_found     = start_found_r;
  assign shift_in_enable = shift_in_enable_r;
  assign shift_data      = shift_data_r;
  assign sol_response    = sol_response_r;

endmodule

// File: tb/tb_work_dispatcher.sv
// Directed bench for work_dispatcher: one instance with SHIFT_GAP=0, one with SHIFT_GAP=2, sharing stimulus.
// With DISPATCH_TIMEOUT_EN a third instance (TIMEOUT_CYCLES=16, own go, no claims) exercises the watchdog.
module tb_work_dispatcher;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, host_wr_en, host_go, abort, result_ack, sol_claim;
  logic [4:0]  host_wr_addr;
  logic [31:0] host_wr_data, sol_nonce;

  logic        busy0, result_valid0, timed_out0, start_found0, shift_in_enable0, sol_response0;
  logic [31:0] result_nonce0, shift_data0;
  logic        busy2, result_valid2, timed_out2, start_found2, shift_in_enable2, sol_response2;
  logic [31:0] result_nonce2, shift_data2;

  int passed = 0;
  int total  = 0;
  logic [31:0] exp_buf [24];

  work_dispatcher #(.SHIFT_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_go(host_go), .abort(abort), .result_ack(result_ack),
    .busy(busy0), .result_valid(result_valid0), .result_nonce(result_nonce0), .timed_out(timed_out0),
    .start_found(start_found0), .shift_in_enable(shift_in_enable0), .shift_data(shift_data0),
    .sol_claim(sol_claim), .sol_nonce(sol_nonce), .sol_response(sol_response0)
  );

  work_dispatcher #(.SHIFT_GAP(2)) dut2 (
    .clk(clk), .rst(rst), .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_go(host_go), .abort(abort), .result_ack(result_ack),
    .busy(busy2), .result_valid(result_valid2), .result_nonce(result_nonce2), .timed_out(timed_out2),
    .start_found(start_found2), .shift_in_enable(shift_in_enable2), .shift_data(shift_data2),
    .sol_claim(sol_claim), .sol_nonce(sol_nonce), .sol_response(sol_response2)
  );

`ifdef DISPATCH_TIMEOUT_EN
  logic        go_t, claim_t;
  logic        busy_t, result_valid_t, timed_out_t, start_found_t, shift_in_enable_t, sol_response_t;
  logic [31:0] result_nonce_t, shift_data_t;

  work_dispatcher #(.SHIFT_GAP(0), .TIMEOUT_CYCLES(32'd16)) dut_t (
    .clk(clk), .rst(rst), .host_wr_en(host_wr_en), .host_wr_addr(host_wr_addr),
    .host_wr_data(host_wr_data), .host_go(go_t), .abort(abort), .result_ack(result_ack),
    .busy(busy_t), .result_valid(result_valid_t), .result_nonce(result_nonce_t), .timed_out(timed_out_t),
    .start_found(start_found_t), .shift_in_enable(shift_in_enable_t), .shift_data(shift_data_t),
    .sol_claim(claim_t), .sol_nonce(sol_nonce), .sol_response(sol_response_t)
  );
`endif

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [4:0] addr, input logic [31:0] data);
    host_wr_en   = 1'b1;
    host_wr_addr = addr;
    host_wr_data = data;
    tick();
    host_wr_en = 1'b0;
  endtask

  // {start_found, shift_in_enable, shift_data} expected c cycles after host_go was sampled
  function automatic logic [33:0] exp_out(input int c, input int g);
    logic        p;
    logic [31:0] d;
    int          k;
    p = 1'b0;
    d = 32'd0;
    if (c >= 2) begin
      k = (c - 2) / (g + 1);
      if (((c - 2) % (g + 1) == 0) && (k < 24)) begin
        p = 1'b1;
        d = exp_buf[k];
      end
    end
    return {(c == 1), p, d};
  endfunction

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    total++;
    if ({busy0, result_valid0, timed_out0, start_found0, shift_in_enable0, sol_response0} !== 6'b0) begin
      $display("FAIL reset_flags0: got %b expected 000000",
               {busy0, result_valid0, timed_out0, start_found0, shift_in_enable0, sol_response0});
    end else passed++;
    total++;
    if ({shift_data0, result_nonce0} !== 64'd0) begin
      $display("FAIL reset_data0: got %h expected 0", {shift_data0, result_nonce0});
    end else passed++;
    total++;
    if ({busy2, result_valid2, timed_out2, start_found2, shift_in_enable2, sol_response2, shift_data2} !== 38'd0) begin
      $display("FAIL reset_dut2: got %h expected 0",
               {busy2, result_valid2, timed_out2, start_found2, shift_in_enable2, sol_response2, shift_data2});
    end else passed++;
    rst = 1'b0;
    tick();
    total++;
    if ({busy0, busy2, start_found0} !== 3'b000) begin
      $display("FAIL reset_release: got %b expected 000", {busy0, busy2, start_found0});
    end else passed++;
  endtask

  task automatic load_pattern();
    for (int i = 0; i < 24; i++) begin
      write_word(i[4:0], 32'hA000_0000 + i);
      exp_buf[i] = 32'hA000_0000 + i;
    end
  endtask

  task automatic test_dispatch(input bit go_write, input logic [4:0] gw_addr, input logic [31:0] gw_data,
                               input bit busy_write);
    host_go = 1'b1;
    if (go_write) begin
      host_wr_en   = 1'b1;
      host_wr_addr = gw_addr;
      host_wr_data = gw_data;
      if (gw_addr < 5'd24) exp_buf[gw_addr] = gw_data;
    end
    tick();
    host_go    = 1'b0;
    host_wr_en = 1'b0;
    if (busy_write) begin
      host_wr_en   = 1'b1;
      host_wr_addr = 5'd3;
      host_wr_data = 32'hBAD0_0003;
    end
    for (int c = 1; c <= 74; c++) begin
      if (c > 1) tick();
      if (c == 2) host_wr_en = 1'b0;
      total++;
      if ({start_found0, shift_in_enable0, shift_data0} !== exp_out(c, 0)) begin
        $display("FAIL dispatch_gap0 c=%0d: got %h expected %h", c,
                 {start_found0, shift_in_enable0, shift_data0}, exp_out(c, 0));
      end else passed++;
      total++;
      if ({start_found2, shift_in_enable2, shift_data2} !== exp_out(c, 2)) begin
        $display("FAIL dispatch_gap2 c=%0d: got %h expected %h", c,
                 {start_found2, shift_in_enable2, shift_data2}, exp_out(c, 2));
      end else passed++;
      total++;
      if ({busy0, busy2} !== 2'b11) begin
        $display("FAIL dispatch_busy c=%0d: got %b expected 11", c, {busy0, busy2});
      end else passed++;
    end
  endtask

  task automatic complete_job(input logic [31:0] n);
    sol_claim = 1'b1;
    sol_nonce = n;
    tick();
    total++;
    if ({sol_response0, result_valid0, result_nonce0, sol_response2, result_valid2, result_nonce2} !==
        {2'b11, n, 2'b11, n}) begin
      $display("FAIL job_capture: got %h expected %h",
               {sol_response0, result_valid0, result_nonce0, sol_response2, result_valid2, result_nonce2},
               {2'b11, n, 2'b11, n});
    end else passed++;
    sol_claim = 1'b0;
    tick();
    total++;
    if ({sol_response0, busy0, sol_response2, busy2} !== 4'b0101) begin
      $display("FAIL job_release: got %b expected 0101", {sol_response0, busy0, sol_response2, busy2});
    end else passed++;
    tick();
    total++;
    if ({busy0, busy2} !== 2'b00) begin
      $display("FAIL job_idle: got %b expected 00", {busy0, busy2});
    end else passed++;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    total++;
    if ({result_valid0, result_nonce0, result_valid2} !== {1'b0, n, 1'b0}) begin
      $display("FAIL job_ack: got %h expected %h", {result_valid0, result_nonce0, result_valid2}, {1'b0, n, 1'b0});
    end else passed++;
  endtask

  task automatic test_solution();
    int r0, r2;
    r0 = 0;
    r2 = 0;
    sol_claim = 1'b1;
    sol_nonce = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      r0 += int'(sol_response0);
      r2 += int'(sol_response2);
    end
    total++;
    if ({r0, r2} !== {32'd1, 32'd1}) begin
      $display("FAIL sol_single_response: got %0d,%0d expected 1,1", r0, r2);
    end else passed++;
    total++;
    if ({result_valid0, result_nonce0, busy0, busy2} !== {1'b1, 32'hDEAD_BEEF, 2'b11}) begin
      $display("FAIL sol_held: got %h expected %h", {result_valid0, result_nonce0, busy0, busy2},
               {1'b1, 32'hDEAD_BEEF, 2'b11});
    end else passed++;
    sol_claim = 1'b0;
    tick();
    total++;
    if ({busy0, busy2, result_valid0, result_valid2} !== 4'b0011) begin
      $display("FAIL sol_to_idle: got %b expected 0011", {busy0, busy2, result_valid0, result_valid2});
    end else passed++;
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    tick();
    total++;
    if ({busy0, start_found0, busy2, start_found2} !== 4'b0000) begin
      $display("FAIL go_before_ack: got %b expected 0000", {busy0, start_found0, busy2, start_found2});
    end else passed++;
    result_ack = 1'b1;
    tick();
    result_ack = 1'b0;
    total++;
    if ({result_valid0, result_valid2, result_nonce0} !== {2'b00, 32'hDEAD_BEEF}) begin
      $display("FAIL sol_ack: got %h expected %h", {result_valid0, result_valid2, result_nonce0},
               {2'b00, 32'hDEAD_BEEF});
    end else passed++;
  endtask

  task automatic test_abort();
    int cnt;
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    total++;
    if ({start_found0, busy0, start_found2, busy2} !== 4'b1111) begin
      $display("FAIL go_after_ack: got %b expected 1111", {start_found0, busy0, start_found2, busy2});
    end else passed++;
    repeat (11) tick();
    total++;
    if ({shift_in_enable0, shift_data0} !== {1'b1, exp_buf[10]}) begin
      $display("FAIL abort_pulse10: got %h expected %h", {shift_in_enable0, shift_data0}, {1'b1, exp_buf[10]});
    end else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    total++;
    if ({start_found0, shift_in_enable0, busy0, start_found2, shift_in_enable2, busy2} !== 6'b100100) begin
      $display("FAIL abort_clear: got %b expected 100100",
               {start_found0, shift_in_enable0, busy0, start_found2, shift_in_enable2, busy2});
    end else passed++;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      cnt += int'(shift_in_enable0) + int'(shift_in_enable2) + int'(start_found0) + int'(start_found2) +
             int'(busy0) + int'(busy2);
    end
    total++;
    if (cnt !== 0) begin
      $display("FAIL abort_quiet: got %0d activity cycles expected 0", cnt);
    end else passed++;
  endtask

  task automatic test_reset_mid_send();
    host_go = 1'b1;
    tick();
    host_go = 1'b0;
    repeat (7) tick();
    total++;
    if ({shift_in_enable0, busy0, shift_in_enable2, busy2} !== 4'b1111) begin
      $display("FAIL midsend_pre: got %b expected 1111", {shift_in_enable0, busy0, shift_in_enable2, busy2});
    end else passed++;
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({busy0, start_found0, shift_in_enable0, shift_data0, busy2, shift_in_enable2, shift_data2} !== 69'd0) begin
      $display("FAIL midsend_async_reset: got %h expected 0",
               {busy0, start_found0, shift_in_enable0, shift_data0, busy2, shift_in_enable2, shift_data2});
    end else passed++;
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 24; i++) exp_buf[i] = 32'd0;
    tick();
  endtask

`ifdef DISPATCH_TIMEOUT_EN
  task automatic test_timeout();
    go_t = 1'b1;
    tick();
    go_t = 1'b0;
    total++;
    if (start_found_t !== 1'b1) begin
      $display("FAIL timeout_start: got %b expected 1", start_found_t);
    end else passed++;
    for (int c = 2; c <= 43; c++) begin
      tick();
      if (c == 41) begin
        total++;
        if ({busy_t, timed_out_t, start_found_t} !== 3'b100) begin
          $display("FAIL timeout_before: got %b expected 100", {busy_t, timed_out_t, start_found_t});
        end else passed++;
      end
      if (c == 42) begin
        total++;
        if ({busy_t, timed_out_t, start_found_t} !== 3'b011) begin
          $display("FAIL timeout_expire: got %b expected 011", {busy_t, timed_out_t, start_found_t});
        end else passed++;
      end
      if (c == 43) begin
        total++;
        if ({busy_t, timed_out_t, start_found_t} !== 3'b010) begin
          $display("FAIL timeout_sticky: got %b expected 010", {busy_t, timed_out_t, start_found_t});
        end else passed++;
      end
    end
    go_t = 1'b1;
    tick();
    go_t = 1'b0;
    total++;
    if ({timed_out_t, start_found_t} !== 2'b01) begin
      $display("FAIL timeout_clear_on_go: got %b expected 01", {timed_out_t, start_found_t});
    end else passed++;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    tick();
  endtask
`endif

  initial begin
    rst          = 1'b1;
    host_wr_en   = 1'b0;
    host_wr_addr = 5'd0;
    host_wr_data = 32'd0;
    host_go      = 1'b0;
    abort        = 1'b0;
    result_ack   = 1'b0;
    sol_claim    = 1'b0;
    sol_nonce    = 32'd0;
`ifdef DISPATCH_TIMEOUT_EN
    go_t    = 1'b0;
    claim_t = 1'b0;
`endif
    for (int i = 0; i < 24; i++) exp_buf[i] = 32'd0;

    test_reset();
    load_pattern();
    test_dispatch(1'b0, 5'd0, 32'd0, 1'b0);
    test_solution();
    test_abort();
    test_dispatch(1'b0, 5'd0, 32'd0, 1'b0);
    complete_job(32'h1234_5678);
    write_word(5'd25, 32'hFFFF_FFFF);
    test_dispatch(1'b1, 5'd5, 32'h5555_0005, 1'b1);
    complete_job(32'hCAFE_0001);
    test_dispatch(1'b0, 5'd0, 32'd0, 1'b0);
    complete_job(32'hCAFE_0002);
    test_reset_mid_send();
    test_dispatch(1'b0, 5'd0, 32'd0, 1'b0);
    complete_job(32'h0BAD_F00D);
`ifdef DISPATCH_TIMEOUT_EN
    test_timeout();
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
